uart_tx: RTL

Transmit half of the 8N1 UART: accepts a byte over a single-cycle send/busy handshake and serialises it on the `tx` pin as one start bit, eight data bits LSB first, and one stop bit. Bit timing comes from an internal divider of the system clock. It sits beside the receiver inside `uart`, driving the `tx` pin and the `tx_data`/`tx_send`/`tx_busy` user interface.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
package uart_pkg;

    localparam int unsigned UART_CLK_FREQ  = 100_000_000;
    localparam int unsigned UART_BAUD      = 115_200;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: flags the last clock of each bit and wraps to zero on its own.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_done = (count_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next count: hold at zero while cleared, restart after the terminal count.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || bit_done) begin
            count_d = '0;
        end
    end

    // Count register; reset arrives through clear.
    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
    parameter int unsigned BAUD     = UART_BAUD
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_send,
    output logic                      tx_busy,
    output logic                      tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned IDX_W        = $clog2(UART_DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      timer_clear;
    logic                      bit_done;

    // Timer idles at zero so the start bit gets a full period from the accepting edge.
    assign timer_clear = rst || (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    // Next-state, shift/index update and next line level.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_send) begin
                    state_d = START;
                    shift_d = tx_data;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Line level is decoded from the next state so tx itself is a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule
